// File: rtl/down_timer.sv
// Programmable down-counting timer with one-cycle terminal-count pulse.
// Optional feature macro: DOWN_TIMER_AUTO_RELOAD_EN (periodic reload).
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_rld;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_dec;
    logic             w_last;
    logic             w_load_zero;
    logic             w_tick;

    // Next-count helpers; the decrement is only used when r_out > 1.
    assign w_dec       = r_out - {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_last      = (r_out == {{(WIDTH-1){1'b0}}, 1'b1});
    assign w_load_zero = (load_value == '0);
    assign w_tick      = (r_state == S_RUN) && enable;

    // Control FSM: clear beats load beats enable; all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_rld   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_state <= S_IDLE;
                r_out   <= '0;
                r_busy  <= 1'b0;
            end else if (load) begin
                r_rld <= load_value;
                if (w_load_zero) begin
                    r_state <= S_IDLE;
                    r_out   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_RUN;
                    r_out   <= load_value;
                    r_busy  <= 1'b1;
                end
            end else if (w_tick) begin
                if (w_last) begin
                    r_done <= 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    r_out  <= r_rld;
`else
                    r_out   <= '0;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`endif
                end else if (r_out != '0) begin
                    r_out <= w_dec;
                end
            end
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

    // While running the count is nonzero and never above the start value.
    a_run_range: assert property (
        @(posedge clk) disable iff (!reset_n)
        r_busy |-> (r_out != '0 && r_out <= r_rld)
    );

    // busy mirrors the FSM state.
    a_busy_state: assert property (
        @(posedge clk) disable iff (!reset_n)
        r_busy == (r_state == S_RUN)
    );

endmodule
